// File: rtl/usb_boot_supervisor_pkg.sv
// Shared types and 48 MHz-derived defaults for the USB boot supervisor.
package usb_boot_supervisor_pkg;

  typedef enum logic [2:0] {
    StPorHold  = 3'd0,
    StAttached = 3'd1,
    StDetach   = 3'd2,
    StBoot     = 3'd3
  } sup_state_e;

  localparam int unsigned ClkHz                = 48_000_000;
  localparam int unsigned DefPorCycles         = 4096;
  localparam int unsigned DefHostTimeoutCycles = 960_000_000;
  localparam int unsigned DefDetachCycles      = ClkHz / 100;
  localparam int unsigned DefSofConfirm        = 4;
  localparam logic [1:0]  DefWarmbootImage     = 2'b01;
  localparam int unsigned FrameIdxW            = 11;

endpackage

// File: rtl/usb_sof_monitor.sv
// Host presence tracking: SOF frame-sequence check, confirmation count and idle timeout.
module usb_sof_monitor
  import usb_boot_supervisor_pkg::*;
#(
  parameter int unsigned HOST_TIMEOUT_CYCLES = DefHostTimeoutCycles,
  parameter int unsigned SOF_CONFIRM         = DefSofConfirm
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 active_i,
  input  logic                 clear_i,
  input  logic                 sof_valid_i,
  input  logic [FrameIdxW-1:0] frame_index_i,
  output logic                 host_present_o,
  output logic                 host_timeout_o
);

  localparam int unsigned   CntW   = $clog2(SOF_CONFIRM + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(SOF_CONFIRM);

  logic [31:0]          idle_q, idle_d;
  logic [CntW-1:0]      sof_cnt_q, sof_cnt_d;
  logic [FrameIdxW-1:0] last_q, last_d;
  logic                 seen_q, seen_d;
  logic                 present_q, present_d;
  logic                 in_seq;

  // The first SOF after (re)activation has no predecessor and always restarts the run.
  assign in_seq = seen_q && (frame_index_i == last_q + FrameIdxW'(1));

  always_comb begin
    idle_d    = idle_q;
    sof_cnt_d = sof_cnt_q;
    last_d    = last_q;
    seen_d    = seen_q;
    present_d = present_q;
    if (!active_i || clear_i) begin
      idle_d    = '0;
      sof_cnt_d = '0;
      last_d    = '0;
      seen_d    = 1'b0;
      present_d = 1'b0;
    end else if (sof_valid_i) begin
      idle_d    = '0;
      last_d    = frame_index_i;
      seen_d    = 1'b1;
      if (!in_seq) begin
        sof_cnt_d = CntW'(1);
      end else if (sof_cnt_q != CntMax) begin
        sof_cnt_d = sof_cnt_q + CntW'(1);
      end
      present_d = (sof_cnt_d == CntMax);
    end else if (idle_q != '1) begin
      idle_d = idle_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      idle_q    <= '0;
      sof_cnt_q <= '0;
      last_q    <= '0;
      seen_q    <= 1'b0;
      present_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      sof_cnt_q <= sof_cnt_d;
      last_q    <= last_d;
      seen_q    <= seen_d;
      present_q <= present_d;
    end
  end

  assign host_present_o = present_q;
  assign host_timeout_o = (idle_q > HOST_TIMEOUT_CYCLES);

endmodule

// File: rtl/usb_boot_supervisor.sv
// Sequences USB engine reset, D+ pull-up and the warm-boot request from PLL lock, SOFs and
// the SPI bridge boot request.
module usb_boot_supervisor
  import usb_boot_supervisor_pkg::*;
#(
  parameter int unsigned POR_CYCLES          = DefPorCycles,
  parameter int unsigned HOST_TIMEOUT_CYCLES = DefHostTimeoutCycles,
  parameter int unsigned DETACH_CYCLES       = DefDetachCycles,
  parameter int unsigned SOF_CONFIRM         = DefSofConfirm,
  parameter logic [1:0]  WARMBOOT_IMAGE      = DefWarmbootImage
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pll_lock,
  input  logic                 sof_valid,
  input  logic [FrameIdxW-1:0] frame_index,
  input  logic                 boot_req,
  output logic                 usb_reset,
  output logic                 usb_pu,
  output logic                 host_present,
  output logic                 warmboot_boot,
  output logic [1:0]           warmboot_sel,
  output logic [2:0]           state
);

  localparam int unsigned    PorW    = $clog2(POR_CYCLES + 1);
  localparam logic [PorW-1:0] PorLast = PorW'(POR_CYCLES - 1);

  sup_state_e      state_q;
  logic            lock_meta_q, lock_s_q;
  logic            boot_req_q;
  logic [PorW-1:0] por_cnt_q;
  logic [31:0]     det_cnt_q;
  logic            usb_reset_q, usb_pu_q, warmboot_q;
  logic            in_attached, boot_rise, host_timeout, leave_attached;

  assign in_attached = (state_q == StAttached);
  // boot_req_q is held low outside ATTACHED so a level already high on entry reads as an edge.
  assign boot_rise      = boot_req & ~boot_req_q;
  assign leave_attached = in_attached & (~lock_s_q | boot_rise | host_timeout);

  usb_sof_monitor #(
    .HOST_TIMEOUT_CYCLES(HOST_TIMEOUT_CYCLES),
    .SOF_CONFIRM        (SOF_CONFIRM)
  ) u_sof_monitor (
    .clk_i         (clk),
    .reset_ni      (reset_n),
    .active_i      (in_attached),
    .clear_i       (leave_attached),
    .sof_valid_i   (sof_valid),
    .frame_index_i (frame_index),
    .host_present_o(host_present),
    .host_timeout_o(host_timeout)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      boot_req_q  <= 1'b0;
      state_q     <= StPorHold;
      por_cnt_q   <= '0;
      det_cnt_q   <= '0;
      usb_reset_q <= 1'b1;
      usb_pu_q    <= 1'b0;
      warmboot_q  <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
      boot_req_q  <= in_attached & boot_req;
      case (state_q)
        StPorHold: begin
          if (!lock_s_q) begin
            por_cnt_q <= '0;
          end else if (por_cnt_q == PorLast) begin
            por_cnt_q   <= '0;
            state_q     <= StAttached;
            usb_reset_q <= 1'b0;
            usb_pu_q    <= 1'b1;
          end else begin
            por_cnt_q <= por_cnt_q + PorW'(1);
          end
        end
        StAttached: begin
          if (!lock_s_q) begin
            state_q     <= StPorHold;
            usb_reset_q <= 1'b1;
            usb_pu_q    <= 1'b0;
          end else if (boot_rise || host_timeout) begin
            state_q     <= StDetach;
            det_cnt_q   <= '0;
            usb_reset_q <= 1'b1;
            usb_pu_q    <= 1'b0;
          end
        end
        StDetach: begin
          if (!lock_s_q) begin
            state_q   <= StPorHold;
            det_cnt_q <= '0;
          end else if (det_cnt_q == DETACH_CYCLES - 1) begin
            state_q    <= StBoot;
            det_cnt_q  <= '0;
            warmboot_q <= 1'b1;
          end else begin
            det_cnt_q <= det_cnt_q + 32'd1;
          end
        end
        StBoot: begin
          // Terminal: lock loss is deliberately ignored once the boot has been requested.
          warmboot_q <= 1'b1;
        end
        default: begin
          state_q     <= StPorHold;
          usb_reset_q <= 1'b1;
          usb_pu_q    <= 1'b0;
        end
      endcase
    end
  end

  assign usb_reset     = usb_reset_q;
  assign usb_pu        = usb_pu_q;
  assign warmboot_boot = warmboot_q;
  assign warmboot_sel  = WARMBOOT_IMAGE;
  assign state         = state_q;

endmodule

// File: tb/tb_usb_boot_supervisor.sv
// Self-checking bench for usb_boot_supervisor: directed table, corner sequences, random run.
module tb_usb_boot_supervisor;

  localparam int POR  = 8;
  localparam int HOST = 100;
  localparam int DET  = 20;
  localparam int CONF = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0, pll_lock = 1'b0, sof_valid = 1'b0, boot_req = 1'b0;
  logic [10:0] frame_index = '0;
  logic        usb_reset, usb_pu, host_present, warmboot_boot;
  logic [1:0]  warmboot_sel;
  logic [2:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  usb_boot_supervisor #(
    .POR_CYCLES         (POR),
    .HOST_TIMEOUT_CYCLES(HOST),
    .DETACH_CYCLES      (DET),
    .SOF_CONFIRM        (CONF),
    .WARMBOOT_IMAGE     (2'b01)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pll_lock     (pll_lock),
    .sof_valid    (sof_valid),
    .frame_index  (frame_index),
    .boot_req     (boot_req),
    .usb_reset    (usb_reset),
    .usb_pu       (usb_pu),
    .host_present (host_present),
    .warmboot_boot(warmboot_boot),
    .warmboot_sel (warmboot_sel),
    .state        (state)
  );

  // ---------------- behavioural reference (phase + timestamps + SOF history) ----------------
  int          m_phase = 0;     // 0 hold, 1 attached, 2 detach, 3 boot
  int          m_locked = 0;    // consecutive locked cycles seen while holding
  int          m_now = 0;
  int          m_ref = 0;       // cycle of attach or of the latest accepted SOF
  int          m_det_start = 0;
  bit          m_present = 1'b0;
  bit          m_prev_breq = 1'b0;
  bit          m_lock_pipe[$] = '{1'b0, 1'b0};
  logic [10:0] m_hist[$];

  function automatic bit hist_in_seq();
    logic [10:0] nxt;
    if (m_hist.size() < CONF) return 1'b0;
    for (int i = 1; i < m_hist.size(); i++) begin
      nxt = m_hist[i-1] + 11'd1;
      if (m_hist[i] != nxt) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_to_hold();
    m_phase   = 0;
    m_locked  = 0;
    m_present = 1'b0;
  endfunction

  function automatic void model_edge(bit r, bit p, bit s, logic [10:0] f, bit b);
    bit ls, prev;
    m_now++;
    if (!r) begin
      model_to_hold();
      m_prev_breq = 1'b0;
      m_lock_pipe = '{1'b0, 1'b0};
      m_hist.delete();
      return;
    end
    ls = m_lock_pipe.pop_front();
    m_lock_pipe.push_back(p);
    prev = m_prev_breq;
    m_prev_breq = (m_phase == 1) ? b : 1'b0;
    case (m_phase)
      0: begin
        if (ls) begin
          m_locked++;
          if (m_locked == POR) begin
            m_phase  = 1;
            m_locked = 0;
            m_ref    = m_now;
            m_hist.delete();
          end
        end else begin
          m_locked = 0;
        end
      end
      1: begin
        if (!ls) begin
          model_to_hold();
        end else if ((b && !prev) || (m_now - m_ref - 1 > HOST)) begin
          m_phase     = 2;
          m_det_start = m_now;
          m_present   = 1'b0;
        end else if (s) begin
          m_ref = m_now;
          m_hist.push_back(f);
          if (m_hist.size() > CONF) void'(m_hist.pop_front());
          m_present = hist_in_seq();
        end
      end
      2: begin
        if (!ls) model_to_hold();
        else if (m_now - m_det_start == DET) m_phase = 3;
      end
      default: ;
    endcase
  endfunction

  // ---------------- helpers ----------------
  function automatic logic [8:0] dut_out();
    return {state, usb_reset, usb_pu, host_present, warmboot_boot, warmboot_sel};
  endfunction

  function automatic logic [8:0] exp_vec(int st, bit ro, bit pu, bit hp, bit wb);
    return {3'(st), ro, pu, hp, wb, 2'b01};
  endfunction

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {state,rst,pu,hp,boot,sel}=%b expected %b", name, got, exp);
    end
  endtask

  task automatic tick(input bit r, input bit p, input bit s, input logic [10:0] f, input bit b);
    reset_n = r; pll_lock = p; sof_valid = s; frame_index = f; boot_req = b;
    @(posedge clk);
    model_edge(r, p, s, f, b);
    #1;
    check($sformatf("model@%0d", m_now), dut_out(),
          exp_vec(m_phase, m_phase != 1, m_phase == 1, m_present, m_phase == 3));
  endtask

  task automatic expect_out(input string name, input int st, input bit ro, input bit pu,
                            input bit hp, input bit wb);
    check(name, dut_out(), exp_vec(st, ro, pu, hp, wb));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string       name;
    int          cycles;
    bit          rst_n, pll, sof;
    logic [10:0] fi;
    bit          breq;
    int          st;
    bit          ro, pu, hp, wb;
  } vec_t;

  function automatic vec_t mk(string n, int c, bit r, bit p, bit s, int f, bit b,
                              int st, bit ro, bit pu, bit hp, bit wb);
    vec_t v;
    v.name = n; v.cycles = c; v.rst_n = r; v.pll = p; v.sof = s; v.fi = 11'(f); v.breq = b;
    v.st = st; v.ro = ro; v.pu = pu; v.hp = hp; v.wb = wb;
    return v;
  endfunction

  vec_t        tbl[$];
  bit          rr, rp, rs, rb;
  logic [10:0] rf, gen_last;

  initial begin
    //                  name            cyc rst pll sof  fi  breq st  ro pu hp wb
    tbl.push_back(mk("reset",           3,  0,  1,  0,   0,   0,  0,  1, 0, 0, 0));
    tbl.push_back(mk("por_wait",        9,  1,  1,  0,   0,   0,  0,  1, 0, 0, 0));
    tbl.push_back(mk("attach",          1,  1,  1,  0,   0,   0,  1,  0, 1, 0, 0));
    tbl.push_back(mk("sof_2045",        1,  1,  1,  1,   2045,0,  1,  0, 1, 0, 0));
    tbl.push_back(mk("gap1",            9,  1,  1,  0,   0,   0,  1,  0, 1, 0, 0));
    tbl.push_back(mk("sof_2046",        1,  1,  1,  1,   2046,0,  1,  0, 1, 0, 0));
    tbl.push_back(mk("gap2",            9,  1,  1,  0,   0,   0,  1,  0, 1, 0, 0));
    tbl.push_back(mk("sof_2047",        1,  1,  1,  1,   2047,0,  1,  0, 1, 0, 0));
    tbl.push_back(mk("gap3",            9,  1,  1,  0,   0,   0,  1,  0, 1, 0, 0));
    tbl.push_back(mk("sof_0_wrap",      1,  1,  1,  1,   0,   0,  1,  0, 1, 1, 0));
    tbl.push_back(mk("present_hold",    9,  1,  1,  0,   0,   0,  1,  0, 1, 1, 0));
    tbl.push_back(mk("sof_5_break",     1,  1,  1,  1,   5,   0,  1,  0, 1, 0, 0));
    tbl.push_back(mk("idle_100",        101,1,  1,  0,   0,   0,  1,  0, 1, 0, 0));
    tbl.push_back(mk("timeout_101",     1,  1,  1,  0,   0,   0,  2,  1, 0, 0, 0));
    tbl.push_back(mk("detach_hold",     19, 1,  1,  0,   0,   0,  2,  1, 0, 0, 0));
    tbl.push_back(mk("boot",            1,  1,  1,  0,   0,   0,  3,  1, 0, 0, 1));
    tbl.push_back(mk("boot_lock_loss",  5,  1,  0,  0,   0,   0,  3,  1, 0, 0, 1));
    tbl.push_back(mk("reset_in_boot",   1,  0,  0,  0,   0,   0,  0,  1, 0, 0, 0));

    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].cycles; c++)
        tick(tbl[i].rst_n, tbl[i].pll, tbl[i].sof, tbl[i].fi, tbl[i].breq);
      check(tbl[i].name, dut_out(),
            exp_vec(tbl[i].st, tbl[i].ro, tbl[i].pu, tbl[i].hp, tbl[i].wb));
    end

    // boot_req rising edge coincident with the SOF that would have confirmed the host
    for (int c = 0; c < 2; c++) tick(0, 1, 0, 0, 0);
    for (int c = 0; c < 10; c++) tick(1, 1, 0, 0, 0);
    expect_out("seqA_attached", 1, 0, 1, 0, 0);
    for (int k = 7; k <= 9; k++) begin
      tick(1, 1, 1, 11'(k), 0);
      tick(1, 1, 0, 0, 0);
      tick(1, 1, 0, 0, 0);
    end
    expect_out("seqA_three_sofs", 1, 0, 1, 0, 0);
    tick(1, 1, 1, 11'd10, 1);
    expect_out("seqA_boot_beats_sof", 2, 1, 0, 0, 0);
    for (int c = 0; c < 19; c++) tick(1, 1, 0, 0, 1);
    expect_out("seqA_detach_19", 2, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 1);
    expect_out("seqA_boot", 3, 1, 0, 0, 1);

    // boot_req level high on entry, then one-cycle lock drop during DETACH
    for (int c = 0; c < 2; c++) tick(0, 1, 0, 0, 1);
    for (int c = 0; c < 10; c++) tick(1, 1, 0, 0, 1);
    expect_out("seqB_attach_level", 1, 0, 1, 0, 0);
    tick(1, 1, 0, 0, 1);
    expect_out("seqB_level_request", 2, 1, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    expect_out("seqB_sync_latency", 2, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    expect_out("seqB_lock_loss", 0, 1, 0, 0, 0);
    for (int c = 0; c < 7; c++) tick(1, 1, 0, 0, 0);
    expect_out("seqB_relock_7", 0, 1, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    expect_out("seqB_reattach", 1, 0, 1, 0, 0);

    // randomized run against the reference model
    gen_last = '0;
    rb = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rr = ($urandom_range(0, 299) != 0);
      rp = ($urandom_range(0, 99) != 0);
      rs = ($urandom_range(0, 9) == 0);
      rf = ($urandom_range(0, 4) == 0) ? 11'($urandom_range(0, 2047)) : gen_last + 11'd1;
      if (rs) gen_last = rf;
      if ($urandom_range(0, 49) == 0) rb = ~rb;
      tick(rr, rp, rs, rf, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
